// File: rtl/psum_output_packer.sv
// Captures four psum lanes, packs complete sets into 32-bit words and streams
// them out of a small FIFO with frame-end marking and sticky overrun reporting.

module psum_capture_lane #(
  parameter int BIT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 val,
  input  logic                 pack,
  input  logic [BIT_WIDTH-1:0] din,
  output logic                 full,
  output logic [BIT_WIDTH-1:0] q,
  output logic                 ovr
);
  // A pack frees the register this cycle, so a coincident value is a reload.
  assign ovr = val && full && !pack;

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      q    <= '0;
    end else if (pack) begin
      full <= val;
      if (val) q <= din;
    end else if (val && !full) begin
      full <= 1'b1;
      q    <= din;
    end
  end
endmodule

module psum_output_packer #(
  parameter int BIT_WIDTH  = 8,
  parameter int NUM_KERNEL = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_WIDTH  = 16,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = AW + 1,
  localparam int W  = BIT_WIDTH * NUM_KERNEL
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIT_WIDTH-1:0] i_psum_kn0,
  input  logic [BIT_WIDTH-1:0] i_psum_kn1,
  input  logic [BIT_WIDTH-1:0] i_psum_kn2,
  input  logic [BIT_WIDTH-1:0] i_psum_kn3,
  input  logic                 i_psum_kn0_val,
  input  logic                 i_psum_kn1_val,
  input  logic                 i_psum_kn2_val,
  input  logic                 i_psum_kn3_val,
  input  logic [LEN_WIDTH-1:0] i_conf_len,
  input  logic                 i_clr_ovf,
  output logic [W-1:0]         o_data,
  output logic                 o_valid,
  output logic                 o_last,
  input  logic                 i_ready,
  output logic [CW-1:0]        o_fifo_count,
  output logic                 o_overflow,
  output logic                 o_busy
);
  logic [NUM_KERNEL-1:0][BIT_WIDTH-1:0] lane_d, lane_q;
  logic [NUM_KERNEL-1:0]                lane_v, lane_full, lane_ovr;

  logic [FIFO_DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]                wptr, rptr;
  logic [CW-1:0]                count;
  logic [LEN_WIDTH-1:0]         wcnt, len_m1;
  logic                         fifo_full, push, pop;

  assign lane_d = {i_psum_kn3, i_psum_kn2, i_psum_kn1, i_psum_kn0};
  assign lane_v = {i_psum_kn3_val, i_psum_kn2_val, i_psum_kn1_val, i_psum_kn0_val};

  genvar g;
  generate
    for (g = 0; g < NUM_KERNEL; g++) begin : g_lane
      psum_capture_lane #(.BIT_WIDTH(BIT_WIDTH)) u_lane (
        .clk  (clk),
        .rst  (rst),
        .val  (lane_v[g]),
        .pack (push),
        .din  (lane_d[g]),
        .full (lane_full[g]),
        .q    (lane_q[g]),
        .ovr  (lane_ovr[g])
      );
    end
  endgenerate

  // Push is decided on start-of-cycle fullness; a concurrent pop does not help.
  assign fifo_full = (count == CW'(FIFO_DEPTH));
  assign push      = (&lane_full) && !fifo_full;
  assign pop       = o_valid && i_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= lane_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Length 0 is treated as 1; wcnt past the end forces a frame boundary.
  assign len_m1 = (i_conf_len == '0) ? '0 : i_conf_len - LEN_WIDTH'(1);
  assign o_last = o_valid && (wcnt >= len_m1);

  always_ff @(posedge clk) begin
    if (rst)       wcnt <= '0;
    else if (pop)  wcnt <= o_last ? '0 : wcnt + LEN_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)             o_overflow <= 1'b0;
    else if (|lane_ovr)  o_overflow <= 1'b1;
    else if (i_clr_ovf)  o_overflow <= 1'b0;
  end

  assign o_valid      = (count != '0);
  assign o_data       = o_valid ? mem[rptr] : '0;
  assign o_fifo_count = count;
  assign o_busy       = (|lane_full) || o_valid;
endmodule

// File: tb/tb_psum_output_packer.sv
// Bench for psum_output_packer: directed vector table, corner-case sequences,
// and randomized traffic against a queue-based reference model.

module tb_psum_output_packer;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  kn0, kn1, kn2, kn3;
  logic        v0, v1, v2, v3;
  logic [15:0] i_conf_len;
  logic        i_clr_ovf, i_ready;
  logic [31:0] o_data;
  logic        o_valid, o_last, o_overflow, o_busy;
  logic [3:0]  o_fifo_count;

  int total = 0;
  int bad   = 0;

  psum_output_packer dut (
    .clk(clk), .rst(rst),
    .i_psum_kn0(kn0), .i_psum_kn1(kn1), .i_psum_kn2(kn2), .i_psum_kn3(kn3),
    .i_psum_kn0_val(v0), .i_psum_kn1_val(v1), .i_psum_kn2_val(v2), .i_psum_kn3_val(v3),
    .i_conf_len(i_conf_len), .i_clr_ovf(i_clr_ovf),
    .o_data(o_data), .o_valid(o_valid), .o_last(o_last), .i_ready(i_ready),
    .o_fifo_count(o_fifo_count), .o_overflow(o_overflow), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  m;
    logic [31:0] d;
    logic        ev;
    logic [31:0] ed;
    logic [3:0]  ec;
    logic        eb;
  } vec_t;

  // reference model state
  logic [7:0]  hold [4];
  bit          has  [4];
  logic [31:0] mq [$];
  int          mw;
  bit          movf;
  int          mlen;

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, e, $time);
    end
  endtask

  // Waits for a falling edge, then applies one cycle of inputs. Outputs seen
  // right after this call reflect state before the coming rising edge.
  task automatic drive(logic [3:0] m, logic [31:0] d, logic rdy, logic clr);
    @(negedge clk);
    {kn3, kn2, kn1, kn0} = d;
    {v3, v2, v1, v0}     = m;
    i_ready   = rdy;
    i_clr_ovf = clr;
  endtask

  function automatic logic [31:0] mkw(int k);
    return 32'h30201000 + 32'(k) * 32'h01010101;
  endfunction

  task automatic model_reset(int len);
    mq.delete();
    for (int i = 0; i < 4; i++) begin has[i] = 0; hold[i] = '0; end
    mw   = 0;
    movf = 0;
    mlen = (len == 0) ? 1 : len;
  endtask

  task automatic model_step(logic [3:0] m, logic [31:0] d, logic rdy, logic clr);
    bit pack, drop;
    pack = has[0] && has[1] && has[2] && has[3] && (mq.size() < 8);
    drop = 0;
    if (mq.size() != 0 && rdy) begin
      if (mw >= mlen - 1) mw = 0; else mw++;
      void'(mq.pop_front());
    end
    if (pack) begin
      mq.push_back({hold[3], hold[2], hold[1], hold[0]});
      for (int i = 0; i < 4; i++) has[i] = 0;
    end
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        if (!has[i]) begin hold[i] = d[8*i +: 8]; has[i] = 1; end
        else drop = 1;
      end
    end
    if (drop) movf = 1;
    else if (clr) movf = 0;
  endtask

  task automatic model_check();
    bit ev, eb;
    ev = (mq.size() != 0);
    eb = ev || has[0] || has[1] || has[2] || has[3];
    chk("rnd_valid", o_valid, ev);
    chk("rnd_count", o_fifo_count, mq.size());
    chk("rnd_busy", o_busy, eb);
    chk("rnd_ovf", o_overflow, movf);
    if (ev) begin
      chk("rnd_data", o_data, mq[0]);
      chk("rnd_last", o_last, mw >= mlen - 1);
    end
  endtask

  task automatic random_run(int len, int cycles);
    logic [3:0]  m;
    logic [31:0] d;
    logic        rdy, clr;
    i_conf_len = 16'(len);
    rst = 1'b1;
    drive(4'h0, 32'h0, 1'b0, 1'b0);
    drive(4'h0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    model_reset(len);
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < 4; i++) m[i] = ($urandom_range(0, 9) < 6);
      d   = $urandom;
      rdy = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 19) == 0);
      drive(m, d, rdy, clr);
      model_check();
      model_step(m, d, rdy, clr);
    end
  endtask

  vec_t vt [19];
  int   npop;

  initial begin
    rst = 1'b1;
    {kn3, kn2, kn1, kn0} = '0;
    {v3, v2, v1, v0} = '0;
    i_ready = 1'b0; i_clr_ovf = 1'b0; i_conf_len = 16'd1;
    repeat (2) @(negedge clk);
    chk("rst_valid", o_valid, 0);
    chk("rst_last", o_last, 0);
    chk("rst_data", o_data, 0);
    chk("rst_count", o_fifo_count, 0);
    chk("rst_ovf", o_overflow, 0);
    chk("rst_busy", o_busy, 0);
    rst = 1'b0;

    // aligned, skewed and back-to-back vectors (frame length 1, ready high)
    vt[0]  = '{4'hF, 32'h44332211, 0, 32'h0, 0, 0};
    vt[1]  = '{4'h0, 32'h0,        0, 32'h0, 0, 1};
    vt[2]  = '{4'h0, 32'h0,        1, 32'h44332211, 1, 1};
    vt[3]  = '{4'h0, 32'h0,        0, 32'h0, 0, 0};
    vt[4]  = '{4'h1, 32'hDDCCBBAA, 0, 32'h0, 0, 0};
    vt[5]  = '{4'h4, 32'hDDCCBBAA, 0, 32'h0, 0, 1};
    vt[6]  = '{4'h0, 32'h0,        0, 32'h0, 0, 1};
    vt[7]  = '{4'h2, 32'hDDCCBBAA, 0, 32'h0, 0, 1};
    vt[8]  = '{4'h0, 32'h0,        0, 32'h0, 0, 1};
    vt[9]  = '{4'h8, 32'hDDCCBBAA, 0, 32'h0, 0, 1};
    vt[10] = '{4'h0, 32'h0,        0, 32'h0, 0, 1};
    vt[11] = '{4'h0, 32'h0,        1, 32'hDDCCBBAA, 1, 1};
    vt[12] = '{4'h0, 32'h0,        0, 32'h0, 0, 0};
    vt[13] = '{4'hF, 32'h13121110, 0, 32'h0, 0, 0};
    vt[14] = '{4'hF, 32'h23222120, 0, 32'h0, 0, 1};
    vt[15] = '{4'hF, 32'h33323130, 1, 32'h13121110, 1, 1};
    vt[16] = '{4'h0, 32'h0,        1, 32'h23222120, 1, 1};
    vt[17] = '{4'h0, 32'h0,        1, 32'h33323130, 1, 1};
    vt[18] = '{4'h0, 32'h0,        0, 32'h0, 0, 0};
    for (int i = 0; i < 19; i++) begin
      drive(vt[i].m, vt[i].d, 1'b1, 1'b0);
      chk($sformatf("vec%0d_valid", i), o_valid, vt[i].ev);
      chk($sformatf("vec%0d_last", i), o_last, vt[i].ev);
      chk($sformatf("vec%0d_count", i), o_fifo_count, vt[i].ec);
      chk($sformatf("vec%0d_busy", i), o_busy, vt[i].eb);
      if (vt[i].ev) chk($sformatf("vec%0d_data", i), o_data, vt[i].ed);
    end

    // backpressure: 10 sets into an 8-deep FIFO, set 9 held, set 10 dropped
    for (int k = 1; k <= 10; k++) drive(4'hF, mkw(k), 1'b0, 1'b0);
    drive(4'h0, 32'h0, 1'b0, 1'b0);
    chk("bp_count", o_fifo_count, 8);
    chk("bp_ovf", o_overflow, 1);
    chk("bp_busy", o_busy, 1);
    for (int k = 1; k <= 9; k++) begin
      drive(4'h0, 32'h0, 1'b1, 1'b0);
      chk($sformatf("bp_valid%0d", k), o_valid, 1);
      chk($sformatf("bp_data%0d", k), o_data, mkw(k));
    end
    drive(4'h0, 32'h0, 1'b1, 1'b1);
    chk("bp_empty", o_valid, 0);
    chk("bp_idle", o_busy, 0);
    drive(4'h0, 32'h0, 1'b1, 1'b0);
    chk("bp_ovf_clr", o_overflow, 0);

    // framing: length 3 over 7 words, then length 0 (every word last)
    i_conf_len = 16'd3;
    npop = 0;
    for (int c = 0; c < 20; c++) begin
      drive((c < 7) ? 4'hF : 4'h0, mkw(c), 1'b1, 1'b0);
      if (o_valid) begin
        npop++;
        chk($sformatf("frm3_last%0d", npop), o_last, (npop % 3) == 0);
        chk($sformatf("frm3_data%0d", npop), o_data, mkw(npop - 1));
      end
    end
    chk("frm3_pops", npop, 7);
    i_conf_len = 16'd0;
    npop = 0;
    for (int c = 0; c < 12; c++) begin
      drive((c < 3) ? 4'hF : 4'h0, mkw(c), 1'b1, 1'b0);
      if (o_valid) begin
        npop++;
        chk($sformatf("frm0_last%0d", npop), o_last, 1);
      end
    end
    chk("frm0_pops", npop, 3);

    // overrun on kn1 coincident with clear: overrun wins, old value kept
    i_conf_len = 16'd1;
    drive(4'h2, 32'h00005500, 1'b1, 1'b0);
    drive(4'h2, 32'h00006600, 1'b1, 1'b1);
    drive(4'h0, 32'h0, 1'b1, 1'b1);
    chk("ovc_wins", o_overflow, 1);
    drive(4'h0, 32'h0, 1'b1, 1'b0);
    chk("ovc_cleared", o_overflow, 0);
    chk("ovc_busy", o_busy, 1);
    drive(4'hD, 32'h77880099, 1'b1, 1'b0);
    drive(4'h0, 32'h0, 1'b1, 1'b0);
    drive(4'h0, 32'h0, 1'b1, 1'b0);
    chk("ovc_valid", o_valid, 1);
    chk("ovc_data", o_data, 32'h77885599);

    // reset mid-run with words buffered, wcnt at 2 and overflow set
    i_conf_len = 16'd3;
    for (int k = 0; k < 7; k++) drive(4'hF, mkw(k + 16), 1'b0, 1'b0);
    drive(4'h0, 32'h0, 1'b0, 1'b0);
    drive(4'h0, 32'h0, 1'b1, 1'b0);
    drive(4'h0, 32'h0, 1'b1, 1'b0);
    drive(4'h2, 32'h00001100, 1'b0, 1'b0);
    drive(4'h2, 32'h00002200, 1'b0, 1'b0);
    drive(4'h0, 32'h0, 1'b0, 1'b0);
    chk("rmr_pre_count", o_fifo_count, 5);
    chk("rmr_pre_ovf", o_overflow, 1);
    rst = 1'b1;
    drive(4'h0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    chk("rmr_valid", o_valid, 0);
    chk("rmr_count", o_fifo_count, 0);
    chk("rmr_ovf", o_overflow, 0);
    chk("rmr_busy", o_busy, 0);
    drive(4'hF, 32'hCAFEF00D, 1'b1, 1'b0);
    drive(4'h0, 32'h0, 1'b1, 1'b0);
    drive(4'h0, 32'h0, 1'b1, 1'b0);
    chk("rmr_first_valid", o_valid, 1);
    chk("rmr_first_data", o_data, 32'hCAFEF00D);
    chk("rmr_first_last", o_last, 0);

    random_run(5, 1500);
    random_run(2, 1500);
    random_run(0, 800);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/psum_output_packer.md
# psum_output_packer

Downstream stage of the DNN accelerator core. Captures the four per-kernel 8-bit partial-sum lanes (kn0..kn3) from the psum accumulator, packs each complete set into one 32-bit word, and buffers the words in a small FIFO. Words drain through a valid/ready stream with a frame-end marker for the output DMA/AXI writer. Lane overruns are reported through a sticky status flag.

## Interface
- BIT_WIDTH, 8, width of one psum lane
- NUM_KERNEL, 4, number of lanes packed per word (fixed at 4 by the port list)
- FIFO_DEPTH, 8, number of packed words buffered; power of two, ≥2
- LEN_WIDTH, 16, width of frame-length config and word counter

- clk  in  1  clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- i_psum_kn0..i_psum_kn3  in  BIT_WIDTH each  lane psum from accumulator
- i_psum_kn0_val..i_psum_kn3_val  in  1 each  lane valid, single-cycle pulse per value
- i_conf_len  in  LEN_WIDTH  words per output frame; 0 behaves as 1
- i_clr_ovf  in  1  clears o_overflow
- o_data  out  BIT_WIDTH*NUM_KERNEL  head word {kn3,kn2,kn1,kn0}, kn0 in LSBs
- o_valid  out  1  FIFO non-empty
- o_last  out  1  head word is last of frame
- i_ready  in  1  consumer accepts head word
- o_fifo_count  out  clog2(FIFO_DEPTH)+1  words currently buffered
- o_overflow  out  1  sticky: a lane value was dropped
- o_busy  out  1  any capture register full, or FIFO non-empty

## Operation
- Capture stage: one holding register plus full flag per lane. A lane valid with the flag clear writes the value and sets the flag.
- Pack: when all four flags are set and the FIFO is not full, push {kn3,kn2,kn1,kn0}, clear all four flags.
- FIFO full while all flags are set: the flags and values hold and no push occurs. Accumulator backpressure is not supported.
- Same-cycle reload: a lane valid arriving in a pack cycle is accepted. The flag ends the cycle set with the new value.
- Overrun: a lane valid arriving while that lane's flag is set and no pack occurs that cycle drops the new value, keeps the old one, and sets o_overflow.
- o_overflow: cleared by rst or i_clr_ovf. A new overrun in the same cycle as i_clr_ovf wins, so the flag stays 1.
- Output: o_valid = (count != 0). A pop occurs when o_valid && i_ready. o_data/o_last are stable while o_valid && !i_ready.
- Push is gated on !full at cycle start only. A same-cycle pop does not enable a push into a full FIFO. Push and pop together in a non-full, non-empty FIFO leave the count unchanged.
- Frame counter: counts popped words, 0..len-1.
  - o_last = o_valid && (wcnt == max(i_conf_len,1)-1).
  - A pop with o_last asserted wraps wcnt to 0.
  - i_conf_len must be stable while o_busy. Behaviour on a change mid-frame is undefined except that wcnt ≥ len forces o_last on the next head word.
- FIFO pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: o_valid 0, o_last 0, o_data 0, o_fifo_count 0, o_overflow 0, o_busy 0. All capture flags, pointers and wcnt are 0.
- Latency: four aligned lane valids in cycle t → flags set after edge t → push at edge t+1 → o_valid=1 in cycle t+2.
- Lanes may arrive in any order or cycles. The push occurs at the edge after the last flag sets.
- Sustained throughput is one word per cycle when lanes pulse every cycle and i_ready=1.
- rst mid-operation discards all captured values and buffered words and zeroes wcnt. No output word completes after rst.

## Test plan
- Aligned stream: lanes 0x11/0x22/0x33/0x44 in cycle 0 with i_ready=1 → o_data=0x44332211, o_valid=1 in cycle 2, one cycle only.
- Skewed lanes: kn0 at t0, kn2 at t1, kn1 at t3, kn3 at t5 → exactly one push at edge t6. o_busy is high t1..until the pop.
- Backpressure: i_ready=0 with 10 aligned sets → o_fifo_count saturates at 8. Sets 9 and 10 remain held or are overrun, and o_overflow=1 once set 10 arrives. Raising i_ready drains 8 words in order, then the held set emerges.
- Framing: i_conf_len=3, 7 words popped → o_last on words 3 and 6. Then i_conf_len=0 → o_last on every word.
- Overflow clear: overrun on kn1 concurrent with i_clr_ovf → o_overflow stays 1. i_clr_ovf alone on the next cycle → 0.
- Reset mid-run: FIFO holding 5 words, rst for 1 cycle → o_valid=0, count 0, o_overflow 0. The next aligned set appears as the first word with o_last governed by a fresh wcnt=0.
